// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-logic frame: phase ordering and scheduler FSM encoding.
package pong_pkg;

  localparam int unsigned NUM_PHASES = 4;
  localparam int unsigned PHASE_W    = 2;
  localparam int unsigned STATE_W    = 3;

  // Phase order within one frame; also the bit index into phase_start/phase_done.
  typedef enum logic [PHASE_W-1:0] {
    PH_PADDLE  = 2'd0,
    PH_BALL    = 2'd1,
    PH_COLLIDE = 2'd2,
    PH_SCORE   = 2'd3
  } phase_e;

  // Scheduler states; phase states sit at phase index + 1 so the mapping is arithmetic.
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_PADDLE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_BALL    = 3'd2;
  localparam logic [STATE_W-1:0] ST_COLLIDE = 3'd3;
  localparam logic [STATE_W-1:0] ST_SCORE   = 3'd4;

  // State that runs a given phase.
  function automatic logic [STATE_W-1:0] phase_to_state(input phase_e ph);
    return STATE_W'(ph) + STATE_W'(1);
  endfunction

  // Phase run by a (non-idle) state.
  function automatic phase_e state_to_phase(input logic [STATE_W-1:0] st);
    return phase_e'(PHASE_W'(st - STATE_W'(1)));
  endfunction

  // Phase that follows a given one; callers handle SCORE as the frame end.
  function automatic phase_e next_phase(input phase_e ph);
    return phase_e'(PHASE_W'(ph) + PHASE_W'(1));
  endfunction

  // One-hot start/done vector for a phase.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input phase_e ph);
    logic [NUM_PHASES-1:0] v;
    v     = '0;
    v[ph] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_edge_sync.sv
// Two-flop synchronizer plus edge register; emits a one-cycle pulse on each rising edge of async_in.
module edge_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic async_in,
  output logic rise_c
);

  logic meta;
  logic s1;
  logic s2;

  // Synchronize async_in and keep the previous synchronized value for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      meta <= 1'b0;
      s1   <= 1'b0;
      s2   <= 1'b0;
    end else begin
      meta <= async_in;
      s1   <= meta;
      s2   <= s1;
    end
  end

  assign rise_c = s1 & ~s2;

endmodule

// File: rtl/game_tick_scheduler.sv
// Runs one game-logic frame (paddle, ball, collide, score) per game_clk rising edge, with a
// one-deep tick queue, per-phase watchdog and sticky overrun/timeout flags.
module game_tick_scheduler
  import pong_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned FRAME_W = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  game_clk,
  input  logic                  pause,
  input  logic [NUM_PHASES-1:0] phase_done,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic                  busy,
  output logic                  frame_end,
  output logic [FRAME_W-1:0]    frame_count,
  output logic                  overrun,
  output logic                  timeout_err
);

  localparam int unsigned   WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic                  tick_c;
  logic                  tick_acc_c;
  phase_e                cur_phase_c;
  logic                  cur_done_c;
  logic                  wd_expired_c;

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_nxt;
  logic                  pending;
  logic                  pending_nxt;
  logic [WD_W-1:0]       wd;
  logic [WD_W-1:0]       wd_nxt;
  logic [NUM_PHASES-1:0] phase_start_nxt;
  logic                  busy_nxt;
  logic                  frame_end_nxt;
  logic [FRAME_W-1:0]    frame_count_nxt;
  logic                  overrun_nxt;
  logic                  timeout_err_nxt;

  // Turn the slow game clock into a single-cycle tick in the CLOCK_50 domain.
  edge_sync u_edge_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .async_in (game_clk),
    .rise_c   (tick_c)
  );

  // State and output registers; reset aborts any frame in flight without a frame_end.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      wd          <= '0;
      phase_start <= '0;
      busy        <= 1'b0;
      frame_end   <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      wd          <= wd_nxt;
      phase_start <= phase_start_nxt;
      busy        <= busy_nxt;
      frame_end   <= frame_end_nxt;
      frame_count <= frame_count_nxt;
      overrun     <= overrun_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Next-state, tick queue, watchdog and registered-output logic.
  always_comb begin
    state_nxt       = state;
    pending_nxt     = pending;
    wd_nxt          = wd;
    phase_start_nxt = '0;
    frame_end_nxt   = 1'b0;
    frame_count_nxt = frame_count;
    overrun_nxt     = overrun;
    timeout_err_nxt = timeout_err;

    tick_acc_c   = tick_c & ~pause;
    cur_phase_c  = state_to_phase(state);
    cur_done_c   = phase_done[cur_phase_c];
    wd_expired_c = (wd == WD_LAST);

    if (state == ST_IDLE) begin
      // A queued tick or a fresh one starts the frame; a fresh tick arriving while the
      // queued one is consumed takes its place in the queue.
      if (pending || tick_acc_c) begin
        state_nxt       = ST_PADDLE;
        phase_start_nxt = phase_onehot(PH_PADDLE);
        wd_nxt          = '0;
        pending_nxt     = pending & tick_acc_c;
      end
    end else begin
      if (tick_acc_c) begin
        if (pending) begin
          overrun_nxt = 1'b1;
        end else begin
          pending_nxt = 1'b1;
        end
      end

      if (cur_done_c || wd_expired_c) begin
        if (!cur_done_c) begin
          timeout_err_nxt = 1'b1;
        end
        wd_nxt = '0;
        if (cur_phase_c == PH_SCORE) begin
          state_nxt       = ST_IDLE;
          frame_end_nxt   = 1'b1;
          frame_count_nxt = frame_count + FRAME_W'(1);
        end else begin
          state_nxt       = phase_to_state(next_phase(cur_phase_c));
          phase_start_nxt = phase_onehot(next_phase(cur_phase_c));
        end
      end else begin
        wd_nxt = wd + WD_W'(1);
      end
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: one instance with a long watchdog and one with a short
// watchdog and narrow frame counter, driven from a single linear stimulus sequence.
module tb_game_tick_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       game_clk = 1'b0;
  logic       pause    = 1'b0;
  logic [3:0] done_a   = 4'd0;
  logic [3:0] done_b   = 4'd0;

  logic [3:0]  ps_a;
  logic        busy_a;
  logic        fe_a;
  logic [15:0] fc_a;
  logic        ovr_a;
  logic        to_a;

  logic [3:0]  ps_b;
  logic        busy_b;
  logic        fe_b;
  logic [1:0]  fc_b;
  logic        ovr_b;
  logic        to_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  logic [3:0] seen;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_tick_scheduler #(.TIMEOUT(1000), .FRAME_W(16)) dut_a (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .game_clk    (game_clk),
    .pause       (pause),
    .phase_done  (done_a),
    .phase_start (ps_a),
    .busy        (busy_a),
    .frame_end   (fe_a),
    .frame_count (fc_a),
    .overrun     (ovr_a),
    .timeout_err (to_a)
  );

  game_tick_scheduler #(.TIMEOUT(8), .FRAME_W(2)) dut_b (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .game_clk    (game_clk),
    .pause       (pause),
    .phase_done  (done_b),
    .phase_start (ps_b),
    .busy        (busy_b),
    .frame_end   (fe_b),
    .frame_count (fc_b),
    .overrun     (ovr_b),
    .timeout_err (to_b)
  );

  // Advance k clocks and land 1 time unit after the last rising edge.
  task automatic cyc(input int k);
    repeat (k) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for any start pulse on instance A; returns cycles waited.
  task automatic wait_start_a(output int cnt);
    cnt = 0;
    do begin
      cyc(1);
      cnt++;
    end while (ps_a == 4'd0 && cnt < 20);
  endtask

  task automatic wait_start_b(output int cnt);
    cnt = 0;
    do begin
      cyc(1);
      cnt++;
    end while (ps_b == 4'd0 && cnt < 20);
  endtask

  // One game_clk period (4 high, 4 low), collecting any start pulse seen on instance A.
  task automatic gclk_pulse(inout logic [3:0] acc);
    game_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin cyc(1); acc = acc | ps_a; end
    game_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(1); acc = acc | ps_a; end
  endtask

  initial begin
    // ---- 1: reset, then one frame with done 2 cycles after each start
    reset = 1'b1;
    cyc(5);
    check("rst_ps",    32'(ps_a),   0);
    check("rst_busy",  32'(busy_a), 0);
    check("rst_fe",    32'(fe_a),   0);
    check("rst_fc",    32'(fc_a),   0);
    check("rst_ovr",   32'(ovr_a),  0);
    check("rst_to",    32'(to_a),   0);
    reset = 1'b0;
    cyc(1);
    game_clk = 1'b1;
    wait_start_a(n);
    check("t1_latency", 32'(n), 3);
    check("t1_ps0",     32'(ps_a), 1);
    check("t1_busy",    32'(busy_a), 1);
    game_clk = 1'b0;
    cyc(2); done_a = 4'b0001; cyc(1); done_a = 4'b0000;
    check("t1_ps1", 32'(ps_a), 2);
    cyc(2); done_a = 4'b0010; cyc(1); done_a = 4'b0000;
    check("t1_ps2", 32'(ps_a), 4);
    cyc(2); done_a = 4'b0100; cyc(1); done_a = 4'b0000;
    check("t1_ps3", 32'(ps_a), 8);
    cyc(2); done_a = 4'b1000; cyc(1); done_a = 4'b0000;
    check("t1_fe",      32'(fe_a),   1);
    check("t1_fc",      32'(fc_a),   1);
    check("t1_busy_lo", 32'(busy_a), 0);
    cyc(1);
    check("t1_fe_once", 32'(fe_a), 0);

    // ---- 3: two more ticks while the frame is busy -> pending, then overrun; two frames total
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
    game_clk = 1'b1;
    wait_start_a(n);
    check("t3_ps0", 32'(ps_a), 1);
    game_clk = 1'b0; cyc(4);
    game_clk = 1'b1; cyc(4);
    check("t3_no_ovr", 32'(ovr_a), 0);
    game_clk = 1'b0; cyc(4);
    game_clk = 1'b1; cyc(4);
    check("t3_ovr", 32'(ovr_a), 1);
    game_clk = 1'b0;
    done_a = 4'b1111;
    cyc(1); check("t3_f1_ps1", 32'(ps_a), 2);
    cyc(1); check("t3_f1_ps2", 32'(ps_a), 4);
    cyc(1); check("t3_f1_ps3", 32'(ps_a), 8);
    cyc(1); check("t3_f1_fe",  32'(fe_a), 1);
    check("t3_f1_fc", 32'(fc_a), 1);
    cyc(1); check("t3_f2_ps0", 32'(ps_a), 1);
    cyc(3);
    cyc(1); check("t3_f2_fe", 32'(fe_a), 1);
    done_a = 4'b0000;
    cyc(10);
    check("t3_fc",       32'(fc_a),   2);
    check("t3_busy_lo",  32'(busy_a), 0);
    check("t3_ovr_kept", 32'(ovr_a),  1);

    // ---- 4: ticks under pause are ignored; unpaused tick runs one frame
    pause = 1'b1;
    seen  = 4'd0;
    gclk_pulse(seen);
    gclk_pulse(seen);
    gclk_pulse(seen);
    check("t4_no_start", 32'(seen),   0);
    check("t4_fc_held",  32'(fc_a),   2);
    check("t4_idle",     32'(busy_a), 0);
    pause  = 1'b0;
    done_a = 4'b1111;
    seen   = 4'd0;
    gclk_pulse(seen);
    cyc(4);
    check("t4_started", 32'(seen),   15);
    check("t4_fc",      32'(fc_a),   3);
    check("t4_busy_lo", 32'(busy_a), 0);
    done_a = 4'b0000;

    // ---- 6: reset during COLLIDE aborts the frame; next tick runs a full frame
    game_clk = 1'b1;
    wait_start_a(n);
    check("t6_ps0", 32'(ps_a), 1);
    game_clk = 1'b0;
    done_a = 4'b0001; cyc(1);
    done_a = 4'b0010; cyc(1);
    check("t6_in_collide", 32'(ps_a), 4);
    done_a = 4'b0000;
    cyc(2);
    reset = 1'b1; cyc(1);
    check("t6_rst_ps",   32'(ps_a),   0);
    check("t6_rst_busy", 32'(busy_a), 0);
    check("t6_rst_fe",   32'(fe_a),   0);
    check("t6_rst_fc",   32'(fc_a),   0);
    check("t6_rst_ovr",  32'(ovr_a),  0);
    check("t6_rst_to",   32'(to_a),   0);
    reset = 1'b0;
    cyc(5);
    check("t6_no_fe",   32'(fe_a),   0);
    check("t6_idle",    32'(busy_a), 0);
    game_clk = 1'b1;
    wait_start_a(n);
    check("t6_new_ps0", 32'(ps_a), 1);
    game_clk = 1'b0;
    done_a = 4'b1111;
    cyc(3);
    check("t6_new_ps3", 32'(ps_a), 8);
    cyc(1);
    check("t6_new_fe", 32'(fe_a), 1);
    check("t6_new_fc", 32'(fc_a), 1);
    done_a = 4'b0000;

    // ---- 2: TIMEOUT=8, ball never done -> forced advance after 8 cycles
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
    game_clk = 1'b1;
    wait_start_b(n);
    check("t2_ps0", 32'(ps_b), 1);
    game_clk = 1'b0;
    done_b = 4'b0001; cyc(1); done_b = 4'b0000;
    check("t2_ps1",    32'(ps_b), 2);
    check("t2_no_to",  32'(to_b), 0);
    wait_start_b(n);
    check("t2_wd_gap", 32'(n),    8);
    check("t2_ps2",    32'(ps_b), 4);
    check("t2_to",     32'(to_b), 1);
    done_b = 4'b0100; cyc(1);
    check("t2_ps3", 32'(ps_b), 8);
    done_b = 4'b1000; cyc(1); done_b = 4'b0000;
    check("t2_fe", 32'(fe_b), 1);
    check("t2_fc", 32'(fc_b), 1);

    // ---- 5: FRAME_W=2 wrap over 5 frames; wrong-bit done ignored in PADDLE
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
    for (int k = 1; k <= 5; k++) begin
      game_clk = 1'b1;
      wait_start_b(n);
      check("t5_ps0", 32'(ps_b), 1);
      game_clk = 1'b0;
      if (k == 1) begin
        done_b = 4'b1000;
        cyc(3);
        check("t5_wrongbit_busy", 32'(busy_b), 1);
        check("t5_wrongbit_ps",   32'(ps_b),   0);
      end
      done_b = 4'b1111;
      cyc(1); check("t5_ps1", 32'(ps_b), 2);
      cyc(1); check("t5_ps2", 32'(ps_b), 4);
      cyc(1); check("t5_ps3", 32'(ps_b), 8);
      cyc(1); check("t5_fe",  32'(fe_b), 1);
      check("t5_fc", 32'(fc_b), 32'(k % 4));
      done_b = 4'b0000;
      cyc(3);
    end
    check("t5_no_to", 32'(to_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
